// File: rtl/sparse_mac_pkg.sv
// sparse_mac_pkg: shared FSM state encoding and default parameters for the sparse MAC lane
package sparse_mac_pkg;
  typedef enum logic [1:0] {IDLE, WAITFLG, COMP, WAITOUT} state_t;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_PSUM_W      = 24;
  localparam int DEF_BLOCK_DEPTH = 32;
  localparam int DEF_ROW_LEN     = 16;
  localparam int DEF_ACT_AW      = 12;
  localparam int DEF_WEI_AW      = 10;
  localparam int DEF_OUT_AW      = 5;
endpackage

// File: rtl/sparse_mac_lane_flg_pick.sv
// flg_pick: lowest-set-bit select of the pair mask plus prefix popcounts of both flag words
//   mask/act/wei in : pending pair mask, activation and weight nonzero flags
//   sel out          : one-hot lowest set bit of mask (0 when mask is empty)
//   pc_act/pc_wei out: set flags strictly below the selected bit
//   pc_all out       : total set activation flags (advances the activation pointer)
module flg_pick #(
  parameter int BLOCK_DEPTH = 32,
  localparam int CW = $clog2(BLOCK_DEPTH + 1)
) (
  input  logic [BLOCK_DEPTH-1:0] mask,
  input  logic [BLOCK_DEPTH-1:0] act,
  input  logic [BLOCK_DEPTH-1:0] wei,
  output logic [BLOCK_DEPTH-1:0] sel,
  output logic [CW-1:0]          pc_act,
  output logic [CW-1:0]          pc_wei,
  output logic [CW-1:0]          pc_all
);
  logic [BLOCK_DEPTH-1:0] below;
  function automatic logic [CW-1:0] pop(input logic [BLOCK_DEPTH-1:0] v);
    pop = '0;
    for (int i = 0; i < BLOCK_DEPTH; i++) pop = pop + CW'(v[i]);
  endfunction
  // two's-complement trick isolates the lowest set bit; sel-1 masks everything beneath it
  assign sel    = mask & (~mask + BLOCK_DEPTH'(1));
  assign below  = sel - BLOCK_DEPTH'(1);
  assign pc_act = pop(act & below);
  assign pc_wei = pop(wei & below);
  assign pc_all = pop(act);
endmodule

// File: rtl/sparse_mac_lane.sv
// sparse_mac_lane: one row of sparse dot products over compressed activation/weight storage
//   start/cfg_*      : row start and configuration (captured on start, restart from any state)
//   flg_*            : per-location nonzero flag words, accepted while flg_rdy
//   rd_*             : single-outstanding operand read port
//   out_*            : psum output with valid/ready handshake
//   busy/done        : row in progress / one-cycle completion pulse
module sparse_mac_lane import sparse_mac_pkg::*; #(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int PSUM_W      = DEF_PSUM_W,
  parameter int BLOCK_DEPTH = DEF_BLOCK_DEPTH,
  parameter int ROW_LEN     = DEF_ROW_LEN,
  parameter int ACT_AW      = DEF_ACT_AW,
  parameter int WEI_AW      = DEF_WEI_AW,
  parameter int OUT_AW      = DEF_OUT_AW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ACT_AW-1:0]        cfg_act_base,
  input  logic [WEI_AW-1:0]        cfg_wei_base,
  input  logic [1:0]               cfg_col,
  input  logic [OUT_AW-1:0]        cfg_win_lo,
  input  logic [OUT_AW-1:0]        cfg_win_hi,
  input  logic                     cfg_sat,
  output logic                     flg_rdy,
  input  logic [BLOCK_DEPTH-1:0]   flg_act,
  input  logic                     flg_act_val,
  input  logic [BLOCK_DEPTH-1:0]   flg_wei,
  input  logic                     flg_wei_val,
  output logic                     rd_req,
  output logic [ACT_AW-1:0]        rd_addr_act,
  output logic [WEI_AW-1:0]        rd_addr_wei,
  input  logic                     rd_val,
  input  logic signed [DATA_W-1:0] rd_act,
  input  logic signed [DATA_W-1:0] rd_wei,
  output logic                     out_val,
  input  logic                     out_rdy,
  output logic [OUT_AW-1:0]        out_addr,
  output logic signed [PSUM_W-1:0] out_psum,
  output logic                     busy,
  output logic                     done
);
  localparam int CW = $clog2(BLOCK_DEPTH + 1);
  localparam int LW = $clog2(ROW_LEN + 1);
  state_t                   state;
  logic [WEI_AW-1:0]        wei_base;
  logic [1:0]               col;
  logic [OUT_AW-1:0]        win_lo, win_hi;
  logic                     sat;
  logic [LW-1:0]            loc_cnt;
  logic [ACT_AW-1:0]        act_ptr;
  logic [BLOCK_DEPTH-1:0]   fa, fw, mask, sel;
  logic [CW-1:0]            pc_act, pc_wei, pc_all;
  logic signed [PSUM_W-1:0] psum, acc;
  logic signed [PSUM_W:0]   sum;
  logic signed [2*DATA_W-1:0] prod;
  logic                     pend, take, fin, in_win, last;
  logic [OUT_AW-1:0]        loc_addr;
  flg_pick #(.BLOCK_DEPTH(BLOCK_DEPTH)) u_pick (
    .mask   (mask),
    .act    (fa),
    .wei    (fw),
    .sel    (sel),
    .pc_act (pc_act),
    .pc_wei (pc_wei),
    .pc_all (pc_all)
  );
  assign flg_rdy     = state == WAITFLG;
  assign out_val     = state == WAITOUT;
  assign busy        = state != IDLE;
  // a returning read frees the single slot in the same cycle, keeping zero-wait memory at one MAC per cycle
  assign rd_req      = !start && state == COMP && |mask && (!pend || rd_val);
  assign rd_addr_act = act_ptr + ACT_AW'(pc_act);
  assign rd_addr_wei = wei_base + WEI_AW'(pc_wei);
  assign take        = state == COMP && pend && rd_val;
  assign prod        = (2*DATA_W)'(rd_act) * (2*DATA_W)'(rd_wei);
  // one guard bit exposes overflow; the clamp direction follows the guard (true) sign
  assign sum         = (PSUM_W+1)'(psum) + (PSUM_W+1)'(prod);
  assign acc         = (sat && sum[PSUM_W] != sum[PSUM_W-1])
                       ? (sum[PSUM_W] ? {1'b1, {(PSUM_W-1){1'b0}}} : {1'b0, {(PSUM_W-1){1'b1}}})
                       : sum[PSUM_W-1:0];
  assign fin         = state == COMP && mask == '0 && !pend;
  // loc_cnt was already advanced when the flags were taken, hence the extra -1
  assign loc_addr    = OUT_AW'(loc_cnt) - OUT_AW'(1) - OUT_AW'(col);
  assign in_win      = loc_addr >= win_lo && loc_addr <= win_hi;
  assign last        = loc_cnt == LW'(ROW_LEN);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      wei_base <= '0;
      col      <= '0;
      win_lo   <= '0;
      win_hi   <= '0;
      sat      <= 1'b0;
      loc_cnt  <= '0;
      act_ptr  <= '0;
      fa       <= '0;
      fw       <= '0;
      mask     <= '0;
      psum     <= '0;
      pend     <= 1'b0;
      out_addr <= '0;
      out_psum <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      pend <= rd_req | (pend & ~rd_val);
      if (rd_req) mask <= mask & ~sel;
      if (take) psum <= acc;
      if (start) begin
        state    <= WAITFLG;
        wei_base <= cfg_wei_base;
        col      <= cfg_col;
        win_lo   <= cfg_win_lo;
        win_hi   <= cfg_win_hi;
        sat      <= cfg_sat;
        loc_cnt  <= '0;
        act_ptr  <= cfg_act_base;
        mask     <= '0;
        psum     <= '0;
        pend     <= 1'b0;
      end else if (state == WAITFLG && flg_act_val && flg_wei_val) begin
        state   <= COMP;
        fa      <= flg_act;
        fw      <= flg_wei;
        mask    <= flg_act & flg_wei;
        psum    <= '0;
        loc_cnt <= loc_cnt + LW'(1);
      end else if (fin) begin
        act_ptr  <= act_ptr + ACT_AW'(pc_all);
        out_addr <= loc_addr;
        out_psum <= psum;
        state    <= in_win ? WAITOUT : last ? IDLE : WAITFLG;
        done     <= !in_win && last;
      end else if (state == WAITOUT && out_rdy) begin
        state <= last ? IDLE : WAITFLG;
        done  <= last;
      end
    end
endmodule

// File: tb/tb_sparse_mac_lane.sv
// tb_sparse_mac_lane: directed scenarios for the sparse MAC lane with a behavioural operand memory
module tb_sparse_mac_lane;
  localparam int DW = 8, PW = 16, BD = 32, RL = 16, AAW = 12, WAW = 10, OAW = 5;
  logic clk = 0, rst_n = 0, start = 0;
  logic [AAW-1:0] cfg_act_base = '0;
  logic [WAW-1:0] cfg_wei_base = '0;
  logic [1:0] cfg_col = '0;
  logic [OAW-1:0] cfg_win_lo = '0, cfg_win_hi = '0;
  logic cfg_sat = 0;
  logic flg_rdy, rd_req, rd_val = 0, out_val, out_rdy = 0, busy, done;
  logic [BD-1:0] flg_act = '0, flg_wei = '0;
  logic flg_act_val = 0, flg_wei_val = 0;
  logic [AAW-1:0] rd_addr_act;
  logic [WAW-1:0] rd_addr_wei;
  logic signed [DW-1:0] rd_act = '0, rd_wei = '0;
  logic [OAW-1:0] out_addr;
  logic signed [PW-1:0] out_psum;
  sparse_mac_lane #(.DATA_W(DW), .PSUM_W(PW), .BLOCK_DEPTH(BD), .ROW_LEN(RL),
                    .ACT_AW(AAW), .WEI_AW(WAW), .OUT_AW(OAW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_act_base(cfg_act_base),
    .cfg_wei_base(cfg_wei_base), .cfg_col(cfg_col), .cfg_win_lo(cfg_win_lo),
    .cfg_win_hi(cfg_win_hi), .cfg_sat(cfg_sat), .flg_rdy(flg_rdy), .flg_act(flg_act),
    .flg_act_val(flg_act_val), .flg_wei(flg_wei), .flg_wei_val(flg_wei_val),
    .rd_req(rd_req), .rd_addr_act(rd_addr_act), .rd_addr_wei(rd_addr_wei),
    .rd_val(rd_val), .rd_act(rd_act), .rd_wei(rd_wei), .out_val(out_val),
    .out_rdy(out_rdy), .out_addr(out_addr), .out_psum(out_psum), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_chk = 0, n_fail = 0;
  logic signed [DW-1:0] act_mem [0:4095];
  logic signed [DW-1:0] wei_mem [0:1023];
  int mem_delay = 0;
  int log_a[$], log_w[$];
  logic hold = 0;
  int oq_a[$], oq_p[$];
  int hs_cyc = 0, done_cyc = 0, done_cnt = 0;
  logic [BD-1:0] la [16], lw [16];
  // operand memory: one request in flight, answered mem_delay cycles after issue
  initial begin
    logic pending;
    int cnt;
    int aa, wa;
    pending = 0; cnt = 0; aa = 0; wa = 0;
    forever begin
      @(negedge clk);
      rd_val = 0;
      if (!rst_n) pending = 0;
      else if (pending) begin
        if (cnt == 0) begin
          rd_val = 1; rd_act = act_mem[aa]; rd_wei = wei_mem[wa]; pending = 0;
        end else cnt--;
      end
      #1;
      if (rst_n && rd_req) begin
        pending = 1; cnt = mem_delay; aa = int'(rd_addr_act); wa = int'(rd_addr_wei);
        log_a.push_back(aa); log_w.push_back(wa);
      end
    end
  end
  // psum sink with a hold control for back-pressure
  initial forever begin
    @(negedge clk);
    #1;
    out_rdy = !hold;
    #1;
    if (out_val && out_rdy) begin
      oq_a.push_back(int'(out_addr)); oq_p.push_back(int'(out_psum)); hs_cyc = cyc;
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic start_row(input int ab, input int wb, input int c, input int lo, input int hi, input int s);
    @(negedge clk);
    cfg_act_base = AAW'(ab); cfg_wei_base = WAW'(wb); cfg_col = 2'(c);
    cfg_win_lo = OAW'(lo); cfg_win_hi = OAW'(hi); cfg_sat = s[0];
    start = 1;
    oq_a.delete(); oq_p.delete(); log_a.delete(); log_w.delete();
    @(negedge clk);
    start = 0;
  endtask
  task automatic feed_loc(input logic [BD-1:0] fa, input logic [BD-1:0] fw);
    int t;
    t = 0;
    @(negedge clk);
    while (!flg_rdy && t < 3000) begin @(negedge clk); t++; end
    if (!flg_rdy) begin
      n_chk++; n_fail++;
      $display("FAIL flg_rdy_timeout: flg_rdy=%0b required 1", flg_rdy);
    end
    flg_act = fa; flg_wei = fw; flg_act_val = 1; flg_wei_val = 1;
    @(negedge clk);
    flg_act_val = 0; flg_wei_val = 0;
  endtask
  task automatic wait_idle;
    int t;
    t = 0;
    while (busy && t < 5000) begin @(negedge clk); t++; end
    if (busy) begin
      n_chk++; n_fail++;
      $display("FAIL idle_timeout: busy=%0b required 0", busy);
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic fill_dense;
    for (int i = 0; i < 512; i++) act_mem[i] = 1;
    for (int i = 0; i < 32; i++) wei_mem[i] = 1;
    for (int i = 0; i < 16; i++) begin la[i] = '1; lw[i] = '1; end
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_chk++; if (flg_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_flg_rdy: got %0b want 0", flg_rdy); end
    n_chk++; if (rd_req !== 1'b0) begin n_fail++; $display("FAIL rst_rd_req: got %0b want 0", rd_req); end
    n_chk++; if (out_val !== 1'b0) begin n_fail++; $display("FAIL rst_out_val: got %0b want 0", out_val); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b want 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %0b want 0", done); end
    n_chk++; if (out_psum !== '0) begin n_fail++; $display("FAIL rst_psum: got %0d want 0", out_psum); end
    rst_n = 1;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_rel_busy: got %0b want 0", busy); end
  endtask
  task automatic test_dense;
    int k, d0;
    fill_dense();
    mem_delay = 0;
    d0 = done_cnt;
    start_row(0, 0, 0, 0, 15, 0);
    feed_loc(la[0], lw[0]);
    // 32 back-to-back reads: issue, 32 data beats, completion, then out_val
    k = 0;
    while (!out_val && k < 200) begin @(negedge clk); k++; end
    n_chk++; if (k !== 34) begin n_fail++; $display("FAIL dense_latency: got %0d want 34", k); end
    for (int i = 1; i < 16; i++) feed_loc(la[i], lw[i]);
    wait_idle();
    n_chk++; if (oq_a.size() !== 16) begin n_fail++; $display("FAIL dense_count: got %0d want 16", oq_a.size()); end
    for (int i = 0; i < oq_a.size(); i++) begin
      n_chk++;
      if (oq_a[i] !== i || oq_p[i] !== 32) begin
        n_fail++; $display("FAIL dense_out[%0d]: got addr %0d psum %0d want addr %0d psum 32", i, oq_a[i], oq_p[i], i);
      end
    end
    n_chk++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL dense_done_cnt: got %0d want 1", done_cnt - d0); end
    n_chk++; if (done_cyc !== hs_cyc + 1) begin n_fail++; $display("FAIL dense_done_time: got %0d want %0d", done_cyc, hs_cyc + 1); end
  endtask
  task automatic test_sparse;
    int ea [3] = '{100, 101, 104};
    int ew [3] = '{0, 1, 0};
    act_mem[100] = 3; act_mem[101] = -2; act_mem[104] = -4;
    wei_mem[0] = 5; wei_mem[1] = 7;
    for (int i = 0; i < 16; i++) begin la[i] = '0; lw[i] = '0; end
    la[0] = 32'h0000_00F0; lw[0] = 32'h0000_0030;
    la[1] = 32'h0000_0001; lw[1] = 32'h0000_0001;
    start_row(100, 0, 0, 0, 15, 0);
    for (int i = 0; i < 16; i++) feed_loc(la[i], lw[i]);
    wait_idle();
    // address = base + number of nonzeros stored below the chosen channel
    n_chk++; if (log_a.size() !== 3) begin n_fail++; $display("FAIL sparse_reads: got %0d want 3", log_a.size()); end
    for (int i = 0; i < 3 && i < log_a.size(); i++) begin
      n_chk++;
      if (log_a[i] !== ea[i] || log_w[i] !== ew[i]) begin
        n_fail++; $display("FAIL sparse_addr[%0d]: got (%0d,%0d) want (%0d,%0d)", i, log_a[i], log_w[i], ea[i], ew[i]);
      end
    end
    n_chk++; if (oq_a.size() !== 16) begin n_fail++; $display("FAIL sparse_count: got %0d want 16", oq_a.size()); end
    for (int i = 0; i < oq_a.size(); i++) begin
      n_chk++;
      if (oq_a[i] !== i || oq_p[i] !== (i == 0 ? 1 : i == 1 ? -20 : 0)) begin
        n_fail++; $display("FAIL sparse_out[%0d]: got addr %0d psum %0d want addr %0d psum %0d", i, oq_a[i], oq_p[i], i, (i == 0 ? 1 : i == 1 ? -20 : 0));
      end
    end
  endtask
  task automatic test_window;
    for (int i = 0; i < 16; i++) begin act_mem[200+i] = DW'(i + 1); la[i] = 32'h1; lw[i] = 32'h1; end
    wei_mem[0] = 3;
    start_row(200, 0, 2, 1, 14, 0);
    for (int i = 0; i < 16; i++) feed_loc(la[i], lw[i]);
    wait_idle();
    n_chk++; if (oq_a.size() !== 13) begin n_fail++; $display("FAIL win_count: got %0d want 13", oq_a.size()); end
    for (int i = 0; i < oq_a.size(); i++) begin
      n_chk++;
      if (oq_a[i] !== i + 1 || oq_p[i] !== 3 * (i + 4)) begin
        n_fail++; $display("FAIL win_out[%0d]: got addr %0d psum %0d want addr %0d psum %0d", i, oq_a[i], oq_p[i], i + 1, 3 * (i + 4));
      end
    end
  endtask
  task automatic test_sat;
    int wv [4] = '{127, 127, -128, -128};
    int sv [4] = '{1, 0, 1, 0};
    int ev [4] = '{32767, -8160, -32768, 4096};
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 32; i++) begin act_mem[i] = 127; wei_mem[i] = DW'(wv[c]); end
      for (int i = 0; i < 16; i++) begin la[i] = '0; lw[i] = '0; end
      la[0] = '1; lw[0] = '1;
      start_row(0, 0, 0, 0, 0, sv[c]);
      for (int i = 0; i < 16; i++) feed_loc(la[i], lw[i]);
      wait_idle();
      n_chk++;
      if (oq_a.size() !== 1) begin
        n_fail++; $display("FAIL sat_count[%0d]: got %0d want 1", c, oq_a.size());
      end else if (oq_a[0] !== 0 || oq_p[0] !== ev[c]) begin
        n_fail++; $display("FAIL sat_out[%0d]: got addr %0d psum %0d want addr 0 psum %0d", c, oq_a[0], oq_p[0], ev[c]);
      end
    end
  endtask
  task automatic test_stall_delay;
    int k;
    fill_dense();
    mem_delay = 3;
    hold = 1;
    start_row(0, 0, 0, 0, 15, 0);
    feed_loc(la[0], lw[0]);
    k = 0;
    while (!out_val && k < 500) begin @(negedge clk); k++; end
    repeat (10) begin
      @(negedge clk);
      #2;
      n_chk++; if (out_val !== 1'b1) begin n_fail++; $display("FAIL stall_val: got %0b want 1", out_val); end
      n_chk++; if (out_addr !== 5'd0) begin n_fail++; $display("FAIL stall_addr: got %0d want 0", out_addr); end
      n_chk++; if (out_psum !== 16'sd32) begin n_fail++; $display("FAIL stall_psum: got %0d want 32", out_psum); end
      n_chk++; if (flg_rdy !== 1'b0) begin n_fail++; $display("FAIL stall_flg_rdy: got %0b want 0", flg_rdy); end
    end
    n_chk++; if (oq_a.size() !== 0) begin n_fail++; $display("FAIL stall_leak: got %0d outputs want 0", oq_a.size()); end
    hold = 0;
    for (int i = 1; i < 16; i++) feed_loc(la[i], lw[i]);
    wait_idle();
    n_chk++; if (oq_a.size() !== 16) begin n_fail++; $display("FAIL delay_count: got %0d want 16", oq_a.size()); end
    for (int i = 0; i < oq_a.size(); i++) begin
      n_chk++;
      if (oq_a[i] !== i || oq_p[i] !== 32) begin
        n_fail++; $display("FAIL delay_out[%0d]: got addr %0d psum %0d want addr %0d psum 32", i, oq_a[i], oq_p[i], i);
      end
    end
    mem_delay = 0;
  endtask
  task automatic test_abort;
    fill_dense();
    mem_delay = 5;
    start_row(0, 0, 0, 0, 15, 0);
    feed_loc(la[0], lw[0]);
    repeat (2) @(negedge clk);
    // a read is in flight here; its late data must not leak into the restarted row
    start_row(0, 0, 0, 0, 15, 0);
    n_chk++; if (flg_rdy !== 1'b1) begin n_fail++; $display("FAIL abort_flg_rdy: got %0b want 1", flg_rdy); end
    n_chk++; if (rd_req !== 1'b0) begin n_fail++; $display("FAIL abort_rd_req: got %0b want 0", rd_req); end
    repeat (10) @(negedge clk);
    mem_delay = 0;
    for (int i = 0; i < 16; i++) feed_loc(la[i], lw[i]);
    wait_idle();
    n_chk++; if (oq_a.size() !== 16) begin n_fail++; $display("FAIL abort_count: got %0d want 16", oq_a.size()); end
    for (int i = 0; i < oq_a.size(); i++) begin
      n_chk++;
      if (oq_a[i] !== i || oq_p[i] !== 32) begin
        n_fail++; $display("FAIL abort_out[%0d]: got addr %0d psum %0d want addr %0d psum 32", i, oq_a[i], oq_p[i], i);
      end
    end
  endtask
  task automatic test_reset_waitout;
    int k;
    fill_dense();
    hold = 1;
    start_row(0, 0, 0, 0, 15, 0);
    feed_loc(la[0], lw[0]);
    k = 0;
    while (!out_val && k < 200) begin @(negedge clk); k++; end
    n_chk++; if (out_val !== 1'b1) begin n_fail++; $display("FAIL rw_reach: out_val %0b want 1", out_val); end
    rst_n = 0;
    #1;
    n_chk++; if (out_val !== 1'b0) begin n_fail++; $display("FAIL rw_out_val: got %0b want 0", out_val); end
    n_chk++; if (out_psum !== '0) begin n_fail++; $display("FAIL rw_psum: got %0d want 0", out_psum); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rw_busy: got %0b want 0", busy); end
    n_chk++; if (flg_rdy !== 1'b0 || rd_req !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rw_ctrl: got flg_rdy %0b rd_req %0b done %0b want 0 0 0", flg_rdy, rd_req, done);
    end
    @(negedge clk);
    rst_n = 1;
    hold = 0;
    repeat (2) @(negedge clk);
    n_chk++; if (busy !== 1'b0 || out_val !== 1'b0) begin
      n_fail++; $display("FAIL rw_after: got busy %0b out_val %0b want 0 0", busy, out_val);
    end
  endtask
  initial begin
    test_reset();
    test_dense();
    test_sparse();
    test_window();
    test_sat();
    test_stall_delay();
    test_abort();
    test_reset_waitout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
